// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round-constant lookup, byte/word/state
// types and the add_round_key FSM encoding.
package aes_pkg;
  localparam int AES_NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic {NOKEY, RUN} ark_state_e;

  // RCON table indexed by the round counter (round r uses RCON[r] to make key r+1)
  function automatic byte_t rcon(input logic [3:0] rnd);
    case (rnd)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; also reused by subBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a_i,
  output byte_t y_o
);
  localparam byte_t SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign y_o = SBOX[a_i];
endmodule

// File: rtl/add_round_key.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion: one expansion step per
// accepted state, wrapping back to the saved cipher key after round NR.
module add_round_key
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round
);
  localparam logic [3:0] LAST_RND = 4'(NR);

  ark_state_e state_q;
  state_t     key_q, saved_q, out_state_q;
  logic [3:0] cnt_q, out_round_q;
  logic       key_valid_q, out_valid_q;
  logic       accept;

  word_t w [4];
  word_t rot_w, sub_w, t_w;
  word_t n0, n1, n2, n3;
  state_t key_next;

  for (genvar g = 0; g < 4; g++) begin : g_word
    assign w[g] = key_q[127-32*g -: 32];
  end

  assign rot_w = {w[3][23:0], w[3][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot_w[31-8*g -: 8]), .y_o(sub_w[31-8*g -: 8]));
  end

  assign t_w      = sub_w ^ {rcon(cnt_q), 24'h0};
  assign n0       = w[0] ^ t_w;
  assign n1       = w[1] ^ n0;
  assign n2       = w[2] ^ n1;
  assign n3       = w[3] ^ n2;
  assign key_next = {n0, n1, n2, n3};

  // A key_load cycle never accepts, so the reload cannot collide with a key advance.
  assign in_ready = (state_q == RUN) && !key_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NOKEY;
      key_q       <= '0;
      saved_q     <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
    end else begin
      if (key_load) begin
        state_q     <= RUN;
        key_q       <= key_in;
        saved_q     <= key_in;
        cnt_q       <= '0;
        key_valid_q <= 1'b1;
      end else if (accept) begin
        if (cnt_q == LAST_RND) begin
          key_q <= saved_q;
          cnt_q <= '0;
        end else begin
          key_q <= key_next;
          cnt_q <= cnt_q + 4'd1;
        end
      end

      if (accept) begin
        out_state_q <= in_state ^ key_q;
        out_round_q <= cnt_q;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign key_valid = key_valid_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
endmodule

// File: tb/tb_add_round_key.sv
// Randomized + directed bench for add_round_key against a FIPS-197 key schedule
// model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_add_round_key;
  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_valid;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;

  add_round_key dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_round(out_round)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 0) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  logic [127:0] rk [11];

  task automatic expand_all(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  typedef struct { logic [127:0] s; logic [3:0] r; } exp_t;
  exp_t sb [$];
  int   m_rnd = 0;
  bit   m_kv  = 0;

  // Evaluate this cycle's handshakes before the rising edge, then move past it.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("key_valid", {127'b0, key_valid}, {127'b0, m_kv});
    chk("in_ready", {127'b0, in_ready}, {127'b0, m_kv && !key_load && (!out_valid || out_ready)});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", {127'b0, out_valid}, 128'h0);
      else begin
        e = sb.pop_front();
        chk("sb_state", out_state, e.s);
        chk("sb_round", {124'b0, out_round}, {124'b0, e.r});
      end
    end
    if (key_load) begin
      expand_all(key_in);
      m_rnd = 0;
      m_kv  = 1;
    end else if (in_valid && in_ready) begin
      e.s = in_state ^ rk[m_rnd];
      e.r = 4'(m_rnd);
      sb.push_back(e);
      m_rnd = (m_rnd == 10) ? 0 : m_rnd + 1;
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] hold_s;
  logic [3:0]   hold_r;

  initial begin
    rst = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_valid", {127'b0, key_valid}, 128'h0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'h0);
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_out_round", {124'b0, out_round}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // no key yet: input must be refused
    in_valid = 1'b1; in_state = {4{$urandom()}};
    repeat (20) begin
      step();
      chk("nokey_out_valid", {127'b0, out_valid}, 128'h0);
    end
    in_valid = 1'b0;

    // known-answer rounds 0 and 1
    key_in = FIPS_KEY; key_load = 1'b1; step(); key_load = 1'b0;
    in_valid = 1'b1; in_state = FIPS_PT; out_ready = 1'b1; step();
    chk("kat_r0_state", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("kat_r0_round", {124'b0, out_round}, 128'd0);
    in_state = '0; step(); in_valid = 1'b0;
    chk("kat_r1_state", out_state, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat_r1_round", {124'b0, out_round}, 128'd1);

    // full schedule plus wrap, back to back
    key_load = 1'b1; step(); key_load = 1'b0;
    in_valid = 1'b1; in_state = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 11) begin
        chk("kat_r10_state", out_state, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("kat_r10_round", {124'b0, out_round}, 128'd10);
      end
      if (i == 12) begin
        chk("wrap_state", out_state, FIPS_KEY);
        chk("wrap_round", {124'b0, out_round}, 128'd0);
      end
    end
    in_valid = 1'b0; step();

    // backpressure hold
    in_valid = 1'b1; in_state = {$urandom(), $urandom(), $urandom(), $urandom()}; out_ready = 1'b0;
    step();
    hold_s = out_state; hold_r = out_round;
    in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (5) begin
      step();
      chk("hold_valid", {127'b0, out_valid}, 128'h1);
      chk("hold_state", out_state, hold_s);
      chk("hold_round", {124'b0, out_round}, {124'b0, hold_r});
    end
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0; step(); step();

    // key reload at round 4 coincident with in_valid
    key_in = FIPS_KEY; key_load = 1'b1; step(); key_load = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin in_state = {$urandom(), $urandom(), $urandom(), $urandom()}; step(); end
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()}; key_load = 1'b1; step();
    key_load = 1'b0; step();
    chk("reload_round", {124'b0, out_round}, 128'd0);
    in_valid = 1'b0; step();

    // randomized traffic with occasional reloads
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_state  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_load  = ($urandom_range(39) == 0);
      key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("drain_empty", 128'(sb.size()), 128'h0);

    // asynchronous reset mid-stream
    in_valid = 1'b1; out_ready = 1'b0; in_state = {4{$urandom()}}; step();
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {127'b0, out_valid}, 128'h0);
    chk("arst_out_state", out_state, 128'h0);
    chk("arst_out_round", {124'b0, out_round}, 128'h0);
    chk("arst_key_valid", {127'b0, key_valid}, 128'h0);
    sb.delete(); m_kv = 0; m_rnd = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) begin
      step();
      chk("post_rst_out_valid", {127'b0, out_valid}, 128'h0);
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
- Final stage of each AES-128 round; sits directly downstream of mixColumns.
- Its output feeds subBytes of the next round, or ciphertext capture after the last round.
- XORs the incoming 16-byte state with the current round key.
- Generates round keys 0..NR on the fly from a loaded cipher key: one key-expansion step per accepted state, no key RAM.
- Valid/ready handshake on input and output; sustains one state per cycle.

Parameters:
- NR, 10, number of rounds; the round index runs 0..NR and wraps.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_load  in  1  one-cycle pulse; loads key_in as the round-0 key.
- key_in  in  128  cipher key, byte 0 = bits [127:120].
- key_valid  out  1  a key is loaded; the block is usable.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  the block accepts in_state this cycle.
- in_state  in  128  state bytes in column-major order; bytes 0-3 are column 0, byte 0 = bits [127:120].
- out_valid  out  1  out_state is valid.
- out_ready  in  1  the consumer accepts out_state.
- out_state  out  128  in_state XOR round key.
- out_round  out  4  round index (0..NR) of the key used.

Behaviour:
- Reset (asynchronous, rst=0):
  - key_valid=0, out_valid=0, out_state=0, out_round=0.
  - Round counter=0; key and saved-key registers=0.
  - FSM enters NOKEY.
- FSM states:
  - NOKEY: in_ready=0. key_load moves to RUN.
  - RUN: in_ready = !out_valid || out_ready. key_load stays in RUN and reloads.
- key_load, any state:
  - Key register and saved-key register <= key_in; round counter <= 0; key_valid <= 1 next cycle.
  - in_ready is forced to 0 in the key_load cycle, so no input handshake occurs.
  - An existing output word is unaffected and drains normally.
- Input accept (in_valid && in_ready), 1-cycle latency:
  - out_state <= in_state ^ key_reg; out_round <= counter; out_valid <= 1.
- Key advance on accept:
  - If counter < NR: key_reg <= expand(key_reg, RCON[counter]); counter++.
  - If counter == NR: key_reg <= saved key; counter <= 0 (wrap for the next block).
- expand(), per FIPS-197 with w0..w3 as the 32-bit words of key_reg:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - Combinational, using 4 S-box instances on w3.
- Output hold:
  - out_valid && !out_ready: out_state and out_round stay stable; in_ready=0.
  - Accept and drain in the same cycle is allowed, giving full throughput.
- out_valid clears on out_ready when there is no new accept.
- Reset mid-stream: all state is lost, including the key; the block returns to NOKEY and requires key_load again.
- in_valid while in NOKEY: ignored (in_ready=0); no output is produced.

Decomposition:
- Package aes_pkg holds:
  - AES_NR (10).
  - RCON table: 01,02,04,08,10,20,40,80,1B,36.
  - Byte/word/state typedefs.
  - FSM state enum (NOKEY, RUN).
- Sub-module aes_sbox: 8-bit combinational forward S-box, shared later with subBytes; instantiated 4x here.

Test Plan:
- Reset then in_valid=1 with no key_load -> in_ready=0, out_valid stays 0 for 20 cycles.
- key_load key 2b7e151628aed2a6abf7158809cf4f3c, then in_state 3243f6a8885a308d313198a2e0370734 -> out_state 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, one cycle after accept.
- Second accept with in_state=0 -> out_state a0fafe1788542cb123a339392a6c7605 (round-1 key), out_round=1.
- 11 back-to-back zero states with out_ready=1:
  - Eleventh output = d014f9a8c9ee2589e13f0cc8b6630ca6, out_round=10.
  - Twelfth zero state -> 2b7e1516...4f3c, out_round=0 (wrap).
- Hold out_ready=0 for 5 cycles with out_valid=1 -> out_state and out_round stable, in_ready=0; release -> no lost or duplicated words.
- Pulse key_load at round 4 together with in_valid=1 -> no accept that cycle; next accept uses the new key with out_round=0. Then assert rst mid-run -> outputs 0 immediately (asynchronously), key_valid=0.
